// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache in front of the IFU.
// A miss refills the whole line through an AXI4 INCR read burst (AR/R only).
module icache_direct #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clock,
    input  logic        rst_n_sync,
    input  logic        req,
    input  logic [31:0] req_addr,
    input  logic        fence_i,
    output logic        cache_valid,
    output logic        hit,
    output logic [31:0] icache_ins,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    output logic [7:0]  M_AXI_ARLEN,
    output logic [2:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    input  logic        M_AXI_RLAST
);

    localparam int WSEL_W = $clog2(WORDS);
    localparam int OFF_W  = 2 + WSEL_W;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_AR,
        S_R,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [31:2]       addr_q;
    logic [31:0]       araddr_q;
    logic [WSEL_W-1:0] cnt_q;
    logic              beatOvf_q;
    logic              poison_q;
    logic [31:0]       ins_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES][WORDS];

    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] word;
    logic [TAG_W-1:0]  tag;
    logic              lookupHit;
    logic              beat;
    logic              lastBeat;
    logic              beatErr;
    logic              unusedBits;

    assign idx        = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign word       = addr_q[OFF_W-1:2];
    assign tag        = addr_q[31:OFF_W+IDX_W];
    assign lookupHit  = valid_q[idx] && (tag_q[idx] == tag);
    assign beat       = (state_q == S_R) && M_AXI_RVALID;
    assign lastBeat   = beat && M_AXI_RLAST;
    assign beatErr    = (M_AXI_RRESP != 2'b00);
    assign unusedBits = ^req_addr[1:0];

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = 8'(WORDS - 1);
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;

    always_ff @(posedge clock or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req) state_d = S_LOOKUP;
            S_LOOKUP: state_d = lookupHit ? S_IDLE : S_AR;
            S_AR:     if (M_AXI_ARREADY) state_d = S_R;
            S_R:      if (lastBeat) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cache_valid   = 1'b0;
        hit           = 1'b0;
        icache_ins    = 32'h0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state_q)
            S_LOOKUP: begin
                if (lookupHit) begin
                    cache_valid = 1'b1;
                    hit         = 1'b1;
                    icache_ins  = data_q[idx][word];
                end
            end
            S_AR:   M_AXI_ARVALID = 1'b1;
            S_R:    M_AXI_RREADY  = 1'b1;
            S_RESP: begin
                cache_valid = 1'b1;
                icache_ins  = ins_q;
            end
            default: ;
        endcase
    end

    // poison_q remembers anything that must keep the refilled line invalid:
    // an RRESP error on any beat or a fence_i seen while the burst is pending.
    always_ff @(posedge clock or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            addr_q    <= '0;
            araddr_q  <= '0;
            cnt_q     <= '0;
            beatOvf_q <= 1'b0;
            poison_q  <= 1'b0;
            ins_q     <= '0;
            valid_q   <= '0;
        end else begin
            if (state_q == S_IDLE && req) begin
                addr_q <= req_addr[31:2];
            end
            if (state_q == S_LOOKUP && !lookupHit) begin
                araddr_q <= {addr_q[31:OFF_W], {OFF_W{1'b0}}};
                poison_q <= 1'b0;
            end
            if (state_q == S_AR && M_AXI_ARREADY) begin
                cnt_q     <= '0;
                beatOvf_q <= 1'b0;
            end
            if ((state_q == S_AR || state_q == S_R) && fence_i) begin
                poison_q <= 1'b1;
            end
            if (beat) begin
                if (beatErr) begin
                    poison_q <= 1'b1;
                end
                if (!beatOvf_q && cnt_q == word) begin
                    ins_q <= M_AXI_RDATA;
                end
                if (cnt_q == {WSEL_W{1'b1}}) begin
                    beatOvf_q <= 1'b1;
                end
                cnt_q <= cnt_q + 1'b1;
            end
            if (fence_i) begin
                valid_q <= '0;
            end else if (lastBeat && !poison_q && !beatErr) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage need no reset; valid_q alone qualifies them.
    always_ff @(posedge clock) begin
        if (beat && !beatOvf_q) begin
            data_q[idx][cnt_q] <= M_AXI_RDATA;
        end
        if (lastBeat) begin
            tag_q[idx] <= tag;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios followed by
// randomized fetches checked against a line-address reference model.
module tb_icache_direct;

    localparam int LINES     = 16;
    localparam int WORDS     = 4;
    localparam int LINE_BYTE = WORDS * 4;

    logic        clock;
    logic        rst_n_sync;
    logic        req;
    logic [31:0] req_addr;
    logic        fence_i;
    logic        cache_valid;
    logic        hit;
    logic [31:0] icache_ins;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic        M_AXI_RLAST;

    int total = 0;
    int bad   = 0;
    bit smallMode = 1'b1;

    // Reference model: which memory line number each slot currently holds.
    bit          lineValid [LINES];
    int unsigned lineNum   [LINES];

    icache_direct #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clock         (clock),
        .rst_n_sync    (rst_n_sync),
        .req           (req),
        .req_addr      (req_addr),
        .fence_i       (fence_i),
        .cache_valid   (cache_valid),
        .hit           (hit),
        .icache_ins    (icache_ins),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_ARLEN   (M_AXI_ARLEN),
        .M_AXI_ARSIZE  (M_AXI_ARSIZE),
        .M_AXI_ARBURST (M_AXI_ARBURST),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY),
        .M_AXI_RLAST   (M_AXI_RLAST)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        if (smallMode) return 32'hA0 + (w % WORDS);
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < LINES; i++) lineValid[i] = 1'b0;
    endtask

    task automatic pulseFence();
        fence_i = 1'b1;
        step();
        fence_i = 1'b0;
        clearModel();
    endtask

    // One fetch from IDLE to IDLE, acting as both IFU and AXI slave.
    task automatic applyStimulus(input logic [31:0] addr, input int arDelay, input int errBeat,
                                 input int fenceBeat, input int nBeats, input bit fenceLookup);
        int unsigned lineNo;
        int          slot;
        bit          expHit;
        bit          poisoned;
        logic [31:0] lineAddr;
        logic [31:0] expIns;
        lineNo   = addr / LINE_BYTE;
        slot     = int'(lineNo % LINES);
        lineAddr = lineNo * LINE_BYTE;
        expHit   = lineValid[slot] && (lineNum[slot] == lineNo);
        expIns   = memWord(addr);
        poisoned = 1'b0;

        req      = 1'b1;
        req_addr = addr;
        step();
        req      = 1'b0;
        fence_i  = fenceLookup;
        checkOutput("lookup_cache_valid", cache_valid, expHit);
        if (expHit) begin
            checkOutput("hit_flag", hit, 1);
            checkOutput("hit_ins", icache_ins, expIns);
        end
        if (fenceLookup) clearModel();
        step();
        fence_i = 1'b0;
        if (expHit) begin
            checkOutput("hit_no_arvalid", M_AXI_ARVALID, 0);
            return;
        end

        checkOutput("ar_valid", M_AXI_ARVALID, 1);
        checkOutput("ar_addr", M_AXI_ARADDR, lineAddr);
        checkOutput("ar_len", M_AXI_ARLEN, WORDS - 1);
        checkOutput("ar_size", M_AXI_ARSIZE, 2);
        checkOutput("ar_burst", M_AXI_ARBURST, 1);
        for (int i = 0; i < arDelay; i++) begin
            step();
            checkOutput("ar_hold_valid", M_AXI_ARVALID, 1);
            checkOutput("ar_hold_addr", M_AXI_ARADDR, lineAddr);
        end
        M_AXI_ARREADY = 1'b1;
        step();
        M_AXI_ARREADY = 1'b0;
        checkOutput("r_ready", M_AXI_RREADY, 1);
        checkOutput("r_no_cache_valid", cache_valid, 0);

        for (int b = 0; b < nBeats; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                M_AXI_RVALID = 1'b0;
                step();
            end
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = (b < WORDS) ? memWord(lineAddr + 32'(b * 4)) : 32'hBAD0_0000 + 32'(b);
            M_AXI_RRESP  = (b == errBeat) ? 2'b10 : 2'b00;
            M_AXI_RLAST  = (b == nBeats - 1);
            fence_i      = (b == fenceBeat);
            step();
            if (b == fenceBeat) begin
                poisoned = 1'b1;
                clearModel();
            end
            if (b == errBeat) poisoned = 1'b1;
        end
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST  = 1'b0;
        M_AXI_RRESP  = 2'b00;
        fence_i      = 1'b0;

        checkOutput("resp_cache_valid", cache_valid, 1);
        checkOutput("resp_hit", hit, 0);
        checkOutput("resp_ins", icache_ins, expIns);
        if (!poisoned) begin
            lineValid[slot] = 1'b1;
            lineNum[slot]   = lineNo;
        end
        step();
        checkOutput("idle_cache_valid", cache_valid, 0);
    endtask

    initial begin
        rst_n_sync    = 1'b1;
        req           = 1'b0;
        req_addr      = 32'h0;
        fence_i       = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RDATA   = 32'h0;
        M_AXI_RRESP   = 2'b00;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RLAST   = 1'b0;
        clearModel();
        #2 rst_n_sync = 1'b0;
        #10;
        checkOutput("reset_cache_valid", cache_valid, 0);
        checkOutput("reset_hit", hit, 0);
        checkOutput("reset_ins", icache_ins, 0);
        checkOutput("reset_arvalid", M_AXI_ARVALID, 0);
        checkOutput("reset_rready", M_AXI_RREADY, 0);
        checkOutput("reset_araddr", M_AXI_ARADDR, 0);
        step();
        rst_n_sync = 1'b1;
        step();

        // Cold miss, hit, mid-line miss
        applyStimulus(32'h3000_0000, 0, -1, -1, WORDS, 1'b0);
        applyStimulus(32'h3000_0008, 0, -1, -1, WORDS, 1'b0);
        applyStimulus(32'h3000_001C, 1, -1, -1, WORDS, 1'b0);
        applyStimulus(32'h3000_0014, 0, -1, -1, WORDS, 1'b0);
        // Conflict eviction with a stalled AR channel
        applyStimulus(32'h3000_0100, 5, -1, -1, WORDS, 1'b0);
        applyStimulus(32'h3000_0000, 5, -1, -1, WORDS, 1'b0);
        // fence_i during refill
        applyStimulus(32'h3000_0040, 0, -1, 1, WORDS, 1'b0);
        applyStimulus(32'h3000_0040, 0, -1, -1, WORDS, 1'b0);
        applyStimulus(32'h3000_0000, 0, -1, -1, WORDS, 1'b0);
        // RRESP error on beat 2
        applyStimulus(32'h3000_0080, 0, 1, -1, WORDS, 1'b0);
        applyStimulus(32'h3000_0080, 0, -1, -1, WORDS, 1'b0);
        // Late RLAST: extra beats must not overwrite the line
        applyStimulus(32'h3000_0204, 0, -1, -1, WORDS + 2, 1'b0);
        applyStimulus(32'h3000_020C, 0, -1, -1, WORDS, 1'b0);
        applyStimulus(32'h3000_0200, 0, -1, -1, WORDS, 1'b0);
        // fence_i together with a hitting lookup
        applyStimulus(32'h3000_0204, 0, -1, -1, WORDS, 1'b1);
        applyStimulus(32'h3000_0204, 0, -1, -1, WORDS, 1'b0);

        // Reset in the middle of a burst
        req      = 1'b1;
        req_addr = 32'h3000_0300;
        step();
        req = 1'b0;
        step();
        M_AXI_ARREADY = 1'b1;
        step();
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b1;
        M_AXI_RDATA   = 32'hA0;
        step();
        rst_n_sync = 1'b0;
        #1;
        checkOutput("midreset_rready", M_AXI_RREADY, 0);
        checkOutput("midreset_cache_valid", cache_valid, 0);
        checkOutput("midreset_araddr", M_AXI_ARADDR, 0);
        M_AXI_RVALID = 1'b0;
        step();
        rst_n_sync = 1'b1;
        clearModel();
        step();
        applyStimulus(32'h3000_0000, 0, -1, -1, WORDS, 1'b0);

        // Randomized traffic over three tags so that slots conflict and hit
        smallMode = 1'b0;
        pulseFence();
        for (int n = 0; n < 160; n++) begin
            logic [31:0] a;
            int errBeat;
            int fenceBeat;
            int nBeats;
            a = 32'h4000_0000 + 32'($urandom_range(0, 2) * LINES * LINE_BYTE)
                + 32'($urandom_range(0, LINES - 1) * LINE_BYTE)
                + 32'($urandom_range(0, WORDS - 1) * 4);
            errBeat   = ($urandom_range(0, 9) == 0)  ? int'($urandom_range(0, WORDS - 1)) : -1;
            fenceBeat = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1;
            nBeats    = ($urandom_range(0, 7) == 0)  ? WORDS + int'($urandom_range(1, 2)) : WORDS;
            applyStimulus(a, int'($urandom_range(0, 3)), errBeat, fenceBeat, nBeats,
                          ($urandom_range(0, 14) == 0));
            if ($urandom_range(0, 19) == 0) pulseFence();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache sitting directly upstream of the IFU.
- Accepts single-cycle fetch requests from the IFU and returns the 32-bit instruction together with a one-cycle valid strobe and a hit flag.
- On a miss it refills a whole line through an AXI4 read-burst master (AR/R channels only) toward the SoC crossbar.
- Provides a fence_i invalidate.

Parameters:
- LINES, 16, number of cache lines; power of 2, >= 2.
- WORDS, 4, 32-bit words per line; power of 2, 2..16.
- Derived, not overridable:
  - OFF_W = 2 + log2(WORDS).
  - IDX_W = log2(LINES).
  - TAG_W = 32 - OFF_W - IDX_W.

Ports:
- clock  in  1  system clock.
- rst_n_sync  in  1  asynchronous active-low reset.
- req  in  1  one-cycle fetch request pulse from the IFU.
- req_addr  in  32  fetch address, valid when req=1; bits [1:0] ignored.
- fence_i  in  1  invalidate all lines, one-cycle pulse.
- cache_valid  out  1  one-cycle strobe; icache_ins and hit are valid this cycle.
- hit  out  1  1 = served from array, 0 = served after refill; qualified by cache_valid.
- icache_ins  out  32  instruction word.
- M_AXI_ARADDR  out  32  line-aligned burst address.
- M_AXI_ARVALID  out  1  AR valid.
- M_AXI_ARREADY  in  1  AR ready.
- M_AXI_ARLEN  out  8  constant WORDS-1.
- M_AXI_ARSIZE  out  3  constant 3'b010.
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR).
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  R valid.
- M_AXI_RREADY  out  1  R ready.
- M_AXI_RLAST  in  1  last beat.

Behaviour:
- Storage:
  - Per line: valid bit, TAG_W tag, WORDS x 32 data.
  - Implemented as flops.
  - Reset clears valid bits only; data and tag contents are don't-care.
- Reset (asynchronous, rst_n_sync=0):
  - state=IDLE.
  - cache_valid=0, hit=0, icache_ins=0.
  - ARVALID=0, RREADY=0, ARADDR=0.
  - All valid bits=0.
  - Reset mid-refill abandons the burst and leaves the line invalid. Outstanding R beats after reset are the interconnect's concern; RREADY=0.
- FSM states and transitions:
  - IDLE:
    - req=1 captures req_addr into addr_q and goes to LOOKUP.
    - req while not in IDLE is ignored; the IFU never issues one before cache_valid.
  - LOOKUP:
    - Combinational compare of valid[idx] and tag[idx] against addr_q.
    - Hit: cache_valid=1, hit=1, icache_ins=data[idx][word], then go to IDLE. Latency is 1 cycle after req.
    - Miss: go to AR. ARADDR={addr_q[31:OFF_W], OFF_W'b0}; ARVALID=1 from the next cycle.
  - AR:
    - ARVALID and ARADDR are held stable until ARREADY.
    - On handshake go to R; beat counter=0.
  - R:
    - RREADY=1.
    - Each RVALID beat writes data[idx][cnt] and increments cnt (width log2(WORDS)).
    - The beat whose cnt equals the requested word is also latched into the ins_q register.
    - On the beat with RLAST=1:
      - tag[idx] <= addr tag.
      - valid[idx] <= 1, unless any beat had RRESP!=0 or a fence_i occurred during the refill.
      - Go to RESP.
    - An early or late RLAST (beat count != WORDS) does not wrap or overrun: only RLAST ends the burst, and writes beyond WORDS-1 are dropped.
  - RESP:
    - cache_valid=1, hit=0, icache_ins=ins_q (refilled word), then go to IDLE.
    - Delivery is 1 cycle after the RLAST beat.
    - On an RRESP error the word is still delivered and the line stays invalid.
- fence_i:
  - In any state, clears all valid bits next edge.
  - If it coincides with a LOOKUP, that lookup is evaluated against pre-clear valid bits.
  - If it occurs during AR or R, the pending refill completes and delivers data but does not set valid.
- Outputs:
  - cache_valid and hit are combinational from state and compare.
  - icache_ins is a mux of the array or ins_q, and is 0 when cache_valid=0.

Test Plan:
- Cold miss:
  - Stimulus: reset, req 0x3000_0000; slave returns 0xA0,0xA1,0xA2,0xA3 with RLAST on beat 4.
  - Required: ARADDR=0x3000_0000, ARLEN=3, ARSIZE=2, ARBURST=1; cache_valid=1 one cycle after the RLAST beat, hit=0, icache_ins=0xA0.
- Hit:
  - Stimulus: after the cold miss, req 0x3000_0008.
  - Required: the next cycle has cache_valid=1, hit=1, icache_ins=0xA2, and no ARVALID ever.
- Mid-line miss:
  - Stimulus: req 0x3000_001C.
  - Required: ARADDR=0x3000_0010, returned word = 4th beat, hit=0; subsequent req 0x3000_0014 is a hit returning the 2nd beat.
- Conflict eviction:
  - Stimulus: req 0x3000_0100 (same index 0); then req 0x3000_0000.
  - Required: both miss with AR issued; ARVALID stays high across 5 cycles of ARREADY=0 with ARADDR stable.
- fence_i during refill:
  - Stimulus: pulse fence_i while in R for 0x3000_0040.
  - Required: data delivered with hit=0; re-request of 0x3000_0040 misses again; a line previously valid at 0x3000_0000 also misses.
- Error and reset:
  - Stimulus A: RRESP=2 on beat 2. Required: data delivered, line not validated, re-request misses.
  - Stimulus B: assert rst_n_sync=0 mid-burst. Required: RREADY=0 and cache_valid=0 immediately; after release, req 0x3000_0000 misses.
